// File: rtl/inst_fifo_dual.sv
// Dual-issue instruction queue: accepts up to two fetched instructions per cycle
// and presents the two oldest entries as the master/slave issue pair.
module inst_fifo_dual #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     master_push_en,
    input  logic [DATA_W-1:0]        master_push_inst,
    input  logic [PC_W-1:0]          master_push_pc,
    input  logic                     slave_push_en,
    input  logic [DATA_W-1:0]        slave_push_inst,
    input  logic [PC_W-1:0]          slave_push_pc,
    input  logic                     master_pop,
    input  logic                     slave_pop,
    output logic                     master_valid,
    output logic [DATA_W-1:0]        master_inst,
    output logic [PC_W-1:0]          master_pc,
    output logic                     slave_valid,
    output logic [DATA_W-1:0]        slave_inst,
    output logic [PC_W-1:0]          slave_pc,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] inst_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_nxt;
    logic [AW-1:0] wr_nxt;

    logic [1:0]    pop_req;
    logic [1:0]    pop_n;
    logic [1:0]    push_req;
    logic [1:0]    push_n;
    logic          push_ok;
    logic [CW-1:0] count_next;

    assign rd_nxt = rd_ptr + AW'(1);
    assign wr_nxt = wr_ptr + AW'(1);

    always_comb begin
        pop_req  = master_pop ? (slave_pop ? 2'd2 : 2'd1) : 2'd0;
        push_req = master_push_en ? (slave_push_en ? 2'd2 : 2'd1) : 2'd0;
        // Pops are clamped to what is actually held; count is 0 or 1 whenever the clamp bites.
        pop_n    = (CW'(pop_req) > count) ? count[1:0] : pop_req;
        // Space freed by a same-cycle pop is not credited, so a pair never lands on an occupied slot.
        push_ok  = ({1'b0, count} + (CW+1)'(push_req)) <= (CW+1)'(DEPTH);
        push_n   = push_ok ? push_req : 2'd0;
        count_next = count + CW'(push_n) - CW'(pop_n);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(pop_n);
            wr_ptr <= wr_ptr + AW'(push_n);
            count  <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush) begin
            if (push_n != 2'd0) begin
                inst_mem[wr_ptr] <= master_push_inst;
                pc_mem[wr_ptr]   <= master_push_pc;
            end
            if (push_n == 2'd2) begin
                inst_mem[wr_nxt] <= slave_push_inst;
                pc_mem[wr_nxt]   <= slave_push_pc;
            end
        end
    end

    always_comb begin
        master_valid = (count != '0);
        slave_valid  = (count >= CW'(2));
        master_inst  = master_valid ? inst_mem[rd_ptr] : '0;
        master_pc    = master_valid ? pc_mem[rd_ptr]   : '0;
        slave_inst   = slave_valid  ? inst_mem[rd_nxt] : '0;
        slave_pc     = slave_valid  ? pc_mem[rd_nxt]   : '0;
        full         = (count >= CW'(DEPTH - 1));
        empty        = (count == '0);
    end

endmodule

// File: tb/tb_inst_fifo_dual.sv
// Directed bench for inst_fifo_dual: reset, pair/partial push-pop, fill/drop, wrap, over-pop, flush.
module tb_inst_fifo_dual;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 32;
    localparam int PC_W   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              master_push_en;
    logic [DATA_W-1:0] master_push_inst;
    logic [PC_W-1:0]   master_push_pc;
    logic              slave_push_en;
    logic [DATA_W-1:0] slave_push_inst;
    logic [PC_W-1:0]   slave_push_pc;
    logic              master_pop;
    logic              slave_pop;
    logic              master_valid;
    logic [DATA_W-1:0] master_inst;
    logic [PC_W-1:0]   master_pc;
    logic              slave_valid;
    logic [DATA_W-1:0] slave_inst;
    logic [PC_W-1:0]   slave_pc;
    logic              full;
    logic              empty;
    logic [$clog2(DEPTH):0] count;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] q[$];
    logic [31:0] next_pc;

    inst_fifo_dual #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .master_push_en(master_push_en), .master_push_inst(master_push_inst),
        .master_push_pc(master_push_pc),
        .slave_push_en(slave_push_en), .slave_push_inst(slave_push_inst),
        .slave_push_pc(slave_push_pc),
        .master_pop(master_pop), .slave_pop(slave_pop),
        .master_valid(master_valid), .master_inst(master_inst), .master_pc(master_pc),
        .slave_valid(slave_valid), .slave_inst(slave_inst), .slave_pc(slave_pc),
        .full(full), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; master_push_en = 0; slave_push_en = 0;
        master_pop = 0; slave_pop = 0;
    endtask

    task automatic drive_push(input logic two, input logic [31:0] pc0, input logic [31:0] pc1);
        master_push_en = 1; master_push_pc = pc0; master_push_inst = pc0 ^ 32'h5A5A_0000;
        slave_push_en  = two; slave_push_pc = pc1; slave_push_inst  = pc1 ^ 32'h5A5A_0000;
    endtask

    initial begin
        rst = 0;
        idle();
        drive_push(1, 32'h1111_0000, 32'h1111_0004);
        master_pop = 1; slave_pop = 1;
        tick(); tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_mvalid", 32'(master_valid), 32'd0);
        chk("rst_minst", master_inst, 32'd0);

        // dual push
        rst = 1; idle();
        master_push_en = 1; master_push_inst = 32'h2401_0001; master_push_pc = 32'hBFC0_0000;
        slave_push_en  = 1; slave_push_inst  = 32'h2402_0002; slave_push_pc  = 32'hBFC0_0004;
        tick(); idle();
        chk("dual_minst", master_inst, 32'h2401_0001);
        chk("dual_spc", slave_pc, 32'hBFC0_0004);
        chk("dual_sinst", slave_inst, 32'h2402_0002);
        chk("dual_count", 32'(count), 32'd2);
        chk("dual_svalid", 32'(slave_valid), 32'd1);

        // partial pop
        master_push_en = 1; master_push_inst = 32'h2403_0003; master_push_pc = 32'hBFC0_0008;
        slave_push_en = 1'b0;
        tick(); idle();
        chk("p3_count", 32'(count), 32'd3);
        master_pop = 1;
        tick(); idle();
        chk("ppop_minst", master_inst, 32'h2402_0002);
        chk("ppop_count", 32'(count), 32'd2);
        chk("ppop_spc", slave_pc, 32'hBFC0_0008);
        slave_pop = 1;
        tick(); idle();
        chk("spop_only_count", 32'(count), 32'd2);
        chk("spop_only_minst", master_inst, 32'h2402_0002);

        // over-pop
        master_pop = 1; slave_pop = 1;
        tick(); idle();
        chk("pop2_count", 32'(count), 32'd0);
        drive_push(0, 32'hBFC0_0100, 32'h0);
        tick(); idle();
        chk("one_mpc", master_pc, 32'hBFC0_0100);
        chk("one_svalid", 32'(slave_valid), 32'd0);
        chk("one_spc", slave_pc, 32'd0);
        master_pop = 1; slave_pop = 1;
        tick(); idle();
        chk("over_count", 32'(count), 32'd0);
        chk("over_empty", 32'(empty), 32'd1);
        chk("over_mvalid", 32'(master_valid), 32'd0);
        master_pop = 1;
        tick(); idle();
        chk("under_count", 32'(count), 32'd0);

        // fill to 14, then 15, drop a pair at 15, single to 16, drop at 16
        next_pc = 32'h0000_1000;
        for (int i = 0; i < 7; i++) begin
            drive_push(1, next_pc, next_pc + 4);
            q.push_back(next_pc); q.push_back(next_pc + 4);
            next_pc += 8;
            tick();
        end
        idle();
        chk("fill14_count", 32'(count), 32'd14);
        chk("fill14_full", 32'(full), 32'd0);
        drive_push(0, next_pc, 32'h0);
        q.push_back(next_pc); next_pc += 4;
        tick(); idle();
        chk("fill15_full", 32'(full), 32'd1);
        drive_push(1, 32'hDEAD_0000, 32'hDEAD_0004);
        tick(); idle();
        chk("drop15_count", 32'(count), 32'd15);
        drive_push(0, next_pc, 32'h0);
        q.push_back(next_pc); next_pc += 4;
        tick(); idle();
        chk("fill16_count", 32'(count), 32'd16);
        chk("fill16_full", 32'(full), 32'd1);
        drive_push(0, 32'hDEAD_0008, 32'h0);
        tick(); idle();
        chk("drop16_count", 32'(count), 32'd16);

        // drain two, then steady pop2+push2 across the wrap
        master_pop = 1; slave_pop = 1;
        tick(); idle();
        void'(q.pop_front()); void'(q.pop_front());
        chk("drain_count", 32'(count), 32'd14);
        for (int i = 0; i < 20; i++) begin
            chk("wrap_mpc", master_pc, q[0]);
            chk("wrap_spc", slave_pc, q[1]);
            chk("wrap_minst", master_inst, q[0] ^ 32'h5A5A_0000);
            master_pop = 1; slave_pop = 1;
            drive_push(1, next_pc, next_pc + 4);
            tick(); idle();
            void'(q.pop_front()); void'(q.pop_front());
            q.push_back(next_pc); q.push_back(next_pc + 4);
            next_pc += 8;
        end
        chk("wrap_count", 32'(count), 32'd14);

        // reduce to 6, then flush with push and pop in flight
        for (int i = 0; i < 4; i++) begin
            master_pop = 1; slave_pop = 1;
            tick(); idle();
            void'(q.pop_front()); void'(q.pop_front());
        end
        chk("pre_flush_count", 32'(count), 32'd6);
        chk("pre_flush_mpc", master_pc, q[0]);
        flush = 1; master_pop = 1; drive_push(1, 32'hBAD0_0000, 32'hBAD0_0004);
        tick(); idle();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_mvalid", 32'(master_valid), 32'd0);
        chk("flush_svalid", 32'(slave_valid), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        drive_push(0, 32'h8000_0180, 32'h0);
        tick(); idle();
        chk("post_flush_mpc", master_pc, 32'h8000_0180);
        chk("post_flush_count", 32'(count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fifo_dual.md
Name: inst_fifo_dual

Overview:
- Dual-issue instruction queue between fetch and the ID stage.
- Accepts up to two fetched instructions per cycle and holds them in order.
- Presents the two oldest entries as the master/slave issue pair. The ID stage uses that pair to index the register file read ports.
- Decouples fetch stalls from issue stalls. Supports pipeline flush on branch/exception redirect.

Parameters:
DEPTH, 16, number of entries; power of two, >= 4
DATA_W, 32, instruction word width
PC_W, 32, PC width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets on next rising edge)
flush  in  1  discard all entries; synchronous
master_push_en  in  1  push older fetched instruction
master_push_inst  in  DATA_W  older instruction
master_push_pc  in  PC_W  older PC
slave_push_en  in  1  push younger fetched instruction; honoured only with master_push_en
slave_push_inst  in  DATA_W  younger instruction
slave_push_pc  in  PC_W  younger PC
master_pop  in  1  ID consumed head entry
slave_pop  in  1  ID consumed head+1 entry; honoured only with master_pop
master_valid  out  1  head entry present
master_inst  out  DATA_W  head instruction (0 when !master_valid)
master_pc  out  PC_W  head PC (0 when !master_valid)
slave_valid  out  1  head+1 entry present
slave_inst  out  DATA_W  head+1 instruction (0 when !slave_valid)
slave_pc  out  PC_W  head+1 PC (0 when !slave_valid)
full  out  1  free entries < 2 (fetch must not push)
empty  out  1  count == 0
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- State: storage array, rd_ptr, wr_ptr ($clog2(DEPTH) bits, natural wrap), count register.
- Reset (rst==0 at clock edge): rd_ptr=wr_ptr=count=0. Outputs: all valids 0, inst/pc outputs 0, empty=1, full=0. Storage contents need not be cleared. Reset overrides flush, push and pop.
- Flush (rst==1, flush==1): same pointer/count effect as reset on the next edge. Same-cycle pushes and pops are discarded.
- Outputs are combinational from registered state only; no push-to-output fall-through.
  - An entry pushed at edge N is visible at the outputs after edge N.
  - master_valid = (count>=1); slave_valid = (count>=2).
  - master_* reads entry rd_ptr; slave_* reads entry rd_ptr+1 (wrapped).
- Effective pop count:
  - pops = master_pop ? (slave_pop ? 2 : 1) : 0.
  - slave_pop without master_pop is ignored.
  - Pops are clamped to the pre-edge count: popping 2 with count==1 pops 1; any pop with count==0 pops 0.
- Effective push count:
  - pushes = master_push_en ? (slave_push_en ? 2 : 1) : 0.
  - slave_push_en alone is ignored.
  - Push is accepted only if pre-edge count + pushes <= DEPTH. Free space freed by a same-cycle pop is not credited.
  - A push that fails this check is dropped entirely (no partial pair).
  - Fetch is required to respect full; dropping is a safety net.
- Writes: master data goes to wr_ptr, slave data to wr_ptr+1 (wrapped). wr_ptr advances by pushes.
- rd_ptr advances by pops. count_next = count + pushes - pops.
- Simultaneous push and pop in one cycle is legal. Order is preserved; entries are never overwritten while occupied.
- full = (DEPTH - count) < 2; empty = (count == 0); both combinational from count.
- Pointer wrap: indices wrap modulo DEPTH. The slave read/write at index DEPTH-1 uses index 0 for the +1 entry.

Test Plan:
- Reset: hold rst=0 for 2 cycles with push/pop asserted -> count=0, empty=1, full=0, master_valid=0, master_inst=0.
- Dual push: push pair (0x24010001,pc 0xBFC00000)/(0x24020002,pc 0xBFC00004); next cycle master_inst=0x24010001, slave_pc=0xBFC00004, count=2.
- Partial pop: 3 entries, master_pop=1, slave_pop=0 -> next cycle master is old entry 2, count=2. slave_pop=1 with master_pop=0 -> no change.
- Fill and wrap: with DEPTH=16, push pairs to count=14 -> full=1 at count 15/16.
  - Push at count=15 is dropped.
  - Then pop 2 + push 2 per cycle for 20 cycles -> PCs emerge strictly in order across the index-15 to 0 wrap.
- Over-pop: count=1, master_pop=slave_pop=1 -> count=0, empty=1, no underflow.
- Flush: count=6 with simultaneous push pair and pop -> next cycle count=0, all valids 0. Push the following cycle appears as master.
